// File: rtl/fb_pkg.sv
// Shared types and limits for the two-port framebuffer arbiter.
package fb_pkg;

    localparam int unsigned X_W          = 9;
    localparam int unsigned Y_W          = 8;
    localparam int unsigned SCREEN_MAX_X = 319;
    localparam int unsigned SCREEN_MAX_Y = 199;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        op_t            op;
        logic           data;
    } req_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Single-pixel strobe/ready port; the same protocol on requester and memory sides.
interface fb_arbiter_if;

    logic [fb_pkg::X_W-1:0] x;
    logic [fb_pkg::Y_W-1:0] y;
    logic                   read;
    logic                   write;
    logic                   in;
    logic                   out;
    logic                   rdy;

    modport master (
        output x, y, read, write, in,
        input  out, rdy
    );

    modport slave (
        input  x, y, read, write, in,
        output out, rdy
    );

endinterface

// File: rtl/fb_req_slot.sv
// Pending-request slot for one requester: latches a strobe and holds it until cleared.
module fb_req_slot
    import fb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           read,
    input  logic           write,
    input  logic           data,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           clear,
    output logic           pending,
    output req_t           req,
    output logic           err
);

    logic strobe;
    logic busy;

    assign strobe = read | write;
    // A slot finishing this cycle can take the next strobe without losing it.
    assign busy   = pending & ~clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            req     <= '0;
            err     <= 1'b0;
        end else begin
            if (strobe && !busy) begin
                pending  <= 1'b1;
                req.x    <= x;
                req.y    <= y;
                req.op   <= write ? OP_WRITE : OP_READ;
                req.data <= data;
            end else if (clear) begin
                pending <= 1'b0;
            end
            if (strobe && busy) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Two-port framebuffer arbiter: scanout (port 0) has priority, GPU (port 1) is starvation-protected.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned MAX_X        = SCREEN_MAX_X,
    parameter int unsigned MAX_Y        = SCREEN_MAX_Y,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    fb_arbiter_if.slave  p0,
    fb_arbiter_if.slave  p1,
    fb_arbiter_if.master mem,
    output logic         err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    state_t         state;
    state_t         next_state;
    req_t           req0;
    req_t           req1;
    req_t           cur;
    logic           pend0;
    logic           pend1;
    logic           err0;
    logic           err1;
    logic           clear0;
    logic           clear1;
    logic           grant;
    logic           sel1;
    logic           oor;
    logic           rd_stb;
    logic           wr_stb;
    logic           rdy0;
    logic           rdy1;
    logic           out0;
    logic           out1;
    logic [SW-1:0]  starve;
    logic [X_W-1:0] x_b;
    logic [Y_W-1:0] y_b;
    logic           in_b;

    fb_req_slot u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .read    (p0.read),
        .write   (p0.write),
        .data    (p0.in),
        .x       (p0.x),
        .y       (p0.y),
        .clear   (clear0),
        .pending (pend0),
        .req     (req0),
        .err     (err0)
    );

    fb_req_slot u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .read    (p1.read),
        .write   (p1.write),
        .data    (p1.in),
        .x       (p1.x),
        .y       (p1.y),
        .clear   (clear1),
        .pending (pend1),
        .req     (req1),
        .err     (err1)
    );

    assign sel1 = pend1 && (!pend0 || (starve >= SW'(STARVE_LIMIT)));
    assign cur  = grant ? req1 : req0;
    assign oor  = (cur.x > X_W'(MAX_X)) || (cur.y > Y_W'(MAX_Y));
    assign err  = err0 | err1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pend0 || pend1) next_state = ISSUE;
            ISSUE:   next_state = oor ? DONE : WAIT;
            WAIT:    if (mem.rdy) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_stb = 1'b0;
        wr_stb = 1'b0;
        rdy0   = 1'b0;
        rdy1   = 1'b0;
        if (state == ISSUE && !oor) begin
            rd_stb = (cur.op == OP_READ);
            wr_stb = (cur.op == OP_WRITE);
        end
        if (state == DONE) begin
            rdy0 = ~grant;
            rdy1 = grant;
        end
    end

    assign clear0 = rdy0;
    assign clear1 = rdy1;

    // Grant, starve count and bus address are all decided at the IDLE->ISSUE edge
    // so the memory strobe in ISSUE sees stable address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= 1'b0;
            starve <= '0;
            x_b    <= '0;
            y_b    <= '0;
            in_b   <= 1'b0;
        end else begin
            if (state == IDLE && (pend0 || pend1)) begin
                grant <= sel1;
                x_b   <= sel1 ? req1.x : req0.x;
                y_b   <= sel1 ? req1.y : req0.y;
                in_b  <= sel1 ? req1.data : req0.data;
            end
            if (!pend1) begin
                starve <= '0;
            end else if (state == IDLE) begin
                starve <= sel1 ? '0 : starve + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0 <= 1'b0;
            out1 <= 1'b0;
        end else if (cur.op == OP_READ) begin
            if (state == WAIT && mem.rdy) begin
                if (grant) out1 <= mem.out;
                else       out0 <= mem.out;
            end else if (state == ISSUE && oor) begin
                if (grant) out1 <= 1'b0;
                else       out0 <= 1'b0;
            end
        end
    end

    assign mem.x     = x_b;
    assign mem.y     = y_b;
    assign mem.in    = in_b;
    assign mem.read  = rd_stb;
    assign mem.write = wr_stb;
    assign p0.rdy    = rdy0;
    assign p1.rdy    = rdy1;
    assign p0.out    = out0;
    assign p1.out    = out1;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a latency-programmable single-pixel memory model.
module tb_fb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fb_arbiter_if p0_if ();
    fb_arbiter_if p1_if ();
    fb_arbiter_if mem_if ();

    logic err;

    fb_arbiter #(.MAX_X(319), .MAX_Y(199), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if),
        .mem (mem_if),
        .err (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory model: rdy_b comes mem_lat cycles after the strobe.
    int   mem_lat   = 2;
    logic mem_rdata = 1'b0;
    int   cnt       = 0;
    logic rd_val    = 1'b0;

    assign mem_if.rdy = (cnt == 1);
    assign mem_if.out = rd_val;

    always @(posedge clk) begin
        if (mem_if.read || mem_if.write) begin
            cnt    <= mem_lat;
            rd_val <= mem_rdata;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    int   cyc = 0;
    int   n_wr = 0, n_rd = 0, n_rdy0 = 0, n_rdy1 = 0;
    int   rdy0_cyc = 0, rdy1_cyc = 0;
    logic rdy0_out = 1'b0, rdy1_out = 1'b0;
    logic [8:0] wx = '0;
    logic [7:0] wy = '0;
    logic       win = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_if.write) begin
            n_wr <= n_wr + 1;
            wx   <= mem_if.x;
            wy   <= mem_if.y;
            win  <= mem_if.in;
        end
        if (mem_if.read) n_rd <= n_rd + 1;
        if (p0_if.rdy) begin
            n_rdy0   <= n_rdy0 + 1;
            rdy0_cyc <= cyc;
            rdy0_out <= p0_if.out;
        end
        if (p1_if.rdy) begin
            n_rdy1   <= n_rdy1 + 1;
            rdy1_cyc <= cyc;
            rdy1_out <= p1_if.out;
        end
    end

    task automatic idle_inputs();
        p0_if.x = '0; p0_if.y = '0; p0_if.read = 1'b0; p0_if.write = 1'b0; p0_if.in = 1'b0;
        p1_if.x = '0; p1_if.y = '0; p1_if.read = 1'b0; p1_if.write = 1'b0; p1_if.in = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({p0_if.rdy, p1_if.rdy, p0_if.out, p1_if.out} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_port_outputs: got %b expected 0000",
                     {p0_if.rdy, p1_if.rdy, p0_if.out, p1_if.out});
        end
        tests++;
        if ({mem_if.read, mem_if.write, mem_if.in} !== 3'b000) begin
            fails++;
            $display("FAIL reset_mem_strobes: got %b expected 000",
                     {mem_if.read, mem_if.write, mem_if.in});
        end
        tests++;
        if (mem_if.x !== 9'd0 || mem_if.y !== 8'd0) begin
            fails++;
            $display("FAIL reset_mem_addr: got x=%0d y=%0d expected 0 0", mem_if.x, mem_if.y);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write1();
        int s, b_rdy1, b_wr, b_rd, k;
        mem_lat = 2;
        b_rdy1 = n_rdy1; b_wr = n_wr; b_rd = n_rd;
        p1_if.x = 9'd10; p1_if.y = 8'd20; p1_if.in = 1'b1; p1_if.write = 1'b1;
        s = cyc;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 30 && n_rdy1 == b_rdy1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        if (n_rdy1 - b_rdy1 != 1) begin
            fails++;
            $display("FAIL write1_rdy_count: got %0d expected 1", n_rdy1 - b_rdy1);
        end
        tests++;
        if (rdy1_cyc - s != 5) begin
            fails++;
            $display("FAIL write1_latency: got %0d expected 5", rdy1_cyc - s);
        end
        tests++;
        if (n_wr - b_wr != 1 || n_rd != b_rd) begin
            fails++;
            $display("FAIL write1_strobes: got wr=%0d rd=%0d expected wr=1 rd=0",
                     n_wr - b_wr, n_rd - b_rd);
        end
        tests++;
        if (wx !== 9'd10 || wy !== 8'd20 || win !== 1'b1) begin
            fails++;
            $display("FAIL write1_bus: got x=%0d y=%0d in=%b expected 10 20 1", wx, wy, win);
        end
    endtask

    task automatic test_simultaneous();
        int s, b_rdy0, b_rdy1, k;
        mem_lat = 2;
        mem_rdata = 1'b1;
        b_rdy0 = n_rdy0; b_rdy1 = n_rdy1;
        p0_if.x = 9'd5; p0_if.y = 8'd5; p0_if.read = 1'b1;
        p1_if.x = 9'd6; p1_if.y = 8'd6; p1_if.in = 1'b0; p1_if.write = 1'b1;
        s = cyc;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 40 && n_rdy1 == b_rdy1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        tests++;
        if (n_rdy0 - b_rdy0 != 1 || n_rdy1 - b_rdy1 != 1) begin
            fails++;
            $display("FAIL simul_rdy_count: got rdy0=%0d rdy1=%0d expected 1 1",
                     n_rdy0 - b_rdy0, n_rdy1 - b_rdy1);
        end
        tests++;
        if (rdy0_cyc - s != 5 || rdy1_cyc - s != 10) begin
            fails++;
            $display("FAIL simul_order: got rdy0 at +%0d rdy1 at +%0d expected +5 +10",
                     rdy0_cyc - s, rdy1_cyc - s);
        end
        tests++;
        if (rdy0_out !== 1'b1 || p0_if.out !== 1'b1) begin
            fails++;
            $display("FAIL simul_out0: got %b (held %b) expected 1", rdy0_out, p0_if.out);
        end
        tests++;
        if (wx !== 9'd6 || wy !== 8'd6 || win !== 1'b0) begin
            fails++;
            $display("FAIL simul_bus1: got x=%0d y=%0d in=%b expected 6 6 0", wx, wy, win);
        end
    endtask

    task automatic test_starve();
        int n0, k;
        logic seen1;
        mem_lat = 1;
        mem_rdata = 1'b1;
        n0 = 0;
        seen1 = 1'b0;
        p0_if.x = 9'd7; p0_if.y = 8'd7; p0_if.read = 1'b1;
        p1_if.x = 9'd8; p1_if.y = 8'd8; p1_if.read = 1'b1;
        @(negedge clk);
        idle_inputs();
        // Port 0 strobes again in each of its own rdy cycles.
        for (k = 0; k < 200 && !seen1; k++) begin
            @(negedge clk);
            p0_if.read = 1'b0;
            if (p1_if.rdy) begin
                seen1 = 1'b1;
            end else if (p0_if.rdy) begin
                n0++;
                p0_if.read = 1'b1;
            end
        end
        p0_if.read = 1'b0;
        repeat (15) @(negedge clk);
        tests++;
        if (seen1 !== 1'b1) begin
            fails++;
            $display("FAIL starve_timeout: got rdy1=%b expected 1", seen1);
        end
        tests++;
        if (n0 != 4) begin
            fails++;
            $display("FAIL starve_count: got %0d port-0 grants expected 4", n0);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL starve_err: got %b expected 0", err);
        end
    endtask

    task automatic test_out_of_range();
        int s, b_rdy1, b_rd, b_wr, k;
        mem_lat = 2;
        mem_rdata = 1'b1;
        // In-range corner reaches memory and leaves out1 = 1.
        b_rdy1 = n_rdy1; b_rd = n_rd;
        p1_if.x = 9'd319; p1_if.y = 8'd199; p1_if.read = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 30 && n_rdy1 == b_rdy1; k++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (n_rd - b_rd != 1 || rdy1_out !== 1'b1) begin
            fails++;
            $display("FAIL corner_read: got reads=%0d out1=%b expected 1 1", n_rd - b_rd, rdy1_out);
        end

        b_rdy1 = n_rdy1; b_rd = n_rd;
        p1_if.x = 9'd320; p1_if.y = 8'd0; p1_if.read = 1'b1;
        s = cyc;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 30 && n_rdy1 == b_rdy1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        if (n_rd != b_rd) begin
            fails++;
            $display("FAIL oor_read_strobe: got %0d reads expected 0", n_rd - b_rd);
        end
        tests++;
        if (n_rdy1 - b_rdy1 != 1 || rdy1_cyc - s != 3) begin
            fails++;
            $display("FAIL oor_latency: got count=%0d at +%0d expected 1 at +3",
                     n_rdy1 - b_rdy1, rdy1_cyc - s);
        end
        tests++;
        if (rdy1_out !== 1'b0 || p1_if.out !== 1'b0) begin
            fails++;
            $display("FAIL oor_out1: got %b (held %b) expected 0", rdy1_out, p1_if.out);
        end

        b_rdy1 = n_rdy1; b_wr = n_wr;
        p1_if.x = 9'd0; p1_if.y = 8'd200; p1_if.in = 1'b1; p1_if.write = 1'b1;
        s = cyc;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 30 && n_rdy1 == b_rdy1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        if (n_wr != b_wr || rdy1_cyc - s != 3) begin
            fails++;
            $display("FAIL oor_write: got writes=%0d rdy at +%0d expected 0 at +3",
                     n_wr - b_wr, rdy1_cyc - s);
        end
    endtask

    task automatic test_overrun();
        int b_rdy1, b_rd, b_wr, k;
        mem_lat = 2;
        b_rdy1 = n_rdy1; b_rd = n_rd; b_wr = n_wr;
        p1_if.x = 9'd1; p1_if.y = 8'd1; p1_if.in = 1'b1; p1_if.write = 1'b1;
        @(negedge clk);
        p1_if.write = 1'b0;
        p1_if.x = 9'd2; p1_if.y = 8'd2; p1_if.read = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 30 && n_rdy1 == b_rdy1; k++) @(negedge clk);
        repeat (15) @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL overrun_err: got %b expected 1", err);
        end
        tests++;
        if (n_rdy1 - b_rdy1 != 1 || n_wr - b_wr != 1 || n_rd != b_rd) begin
            fails++;
            $display("FAIL overrun_dropped: got rdy1=%0d wr=%0d rd=%0d expected 1 1 0",
                     n_rdy1 - b_rdy1, n_wr - b_wr, n_rd - b_rd);
        end
    endtask

    task automatic test_reset_mid();
        int b_rdy0, k;
        logic seen;
        mem_lat = 4;
        seen = 1'b0;
        b_rdy0 = n_rdy0;
        p0_if.x = 9'd2; p0_if.y = 8'd2; p0_if.read = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (k = 0; k < 20 && !seen; k++) begin
            if (mem_if.read) seen = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (seen !== 1'b1) begin
            fails++;
            $display("FAIL midrst_issue_timeout: got read_b=%b expected 1", seen);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({p0_if.rdy, p1_if.rdy, p0_if.out, p1_if.out, mem_if.read, mem_if.write} !== 6'b0) begin
            fails++;
            $display("FAIL midrst_outputs: got %b expected 000000",
                     {p0_if.rdy, p1_if.rdy, p0_if.out, p1_if.out, mem_if.read, mem_if.write});
        end
        tests++;
        if (mem_if.x !== 9'd0 || mem_if.y !== 8'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL midrst_bus_err: got x=%0d y=%0d err=%b expected 0 0 0",
                     mem_if.x, mem_if.y, err);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (n_rdy0 != b_rdy0) begin
            fails++;
            $display("FAIL midrst_no_rdy: got %0d rdy0 pulses expected 0", n_rdy0 - b_rdy0);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write1();
        test_simultaneous();
        test_starve();
        test_out_of_range();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
